// File: rtl/au_seq_multi.sv
// ---------------------------------------------------------------------------
// au_seq_multi
//   Multi-lane sequential arithmetic unit. NCH lanes execute one shared
//   operation (SUM/SUB/MUL/DIV) in lockstep behind a valid/ready handshake.
//   SUM/SUB/MUL complete in one cycle. DIV is a restoring shift-subtract
//   divider that produces one quotient bit per cycle, with all lanes in
//   parallel. Results are registered and held until the consumer takes them.
//
// Parameters
//   WIDTH  operand width per lane (>=2)
//   NCH    lane count (>=1)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   command valid
//   in_ready   unit can accept a command (state IDLE)
//   op         0=SUM 1=SUB 2=MUL 3=DIV
//   a, b       lane i operands at [i*WIDTH +: WIDTH], unsigned
//   out_valid  result valid (state DONE)
//   out_ready  consumer accepts result
//   out        lane i result at [i*2*WIDTH +: 2*WIDTH]
//   dz         lane i divide-by-zero flag, meaningful with out_valid for DIV
//   busy       state != IDLE
//
// Build option
//   AU_REM_EN  when defined, a DIV lane result is {remainder, quotient};
//              otherwise it is {zeros, quotient}.
// ---------------------------------------------------------------------------
module au_seq_multi #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NCH   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              op,
  input  logic [NCH*WIDTH-1:0]    a,
  input  logic [NCH*WIDTH-1:0]    b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*2*WIDTH-1:0]  out,
  output logic [NCH-1:0]          dz,
  output logic                    busy
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      count;

  logic               load_arith;
  logic               load_div;
  logic               div_step;
  logic               div_last;

  logic [NCH*DW-1:0]  arith_all;
  logic [NCH*DW-1:0]  div_all;
  logic [NCH-1:0]     dz_all;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin : p_next
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          state_nxt = (op == OP_DIV) ? S_DIV : S_DONE;
        end
      end
      S_DIV: begin
        if (count == CW'(WIDTH - 1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake decode and datapath controls, all derived from the state register
  always_comb begin : p_out
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    load_arith = 1'b0;
    load_div   = 1'b0;
    div_step   = 1'b0;
    div_last   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready   = 1'b1;
        busy       = 1'b0;
        load_arith = in_valid && (op != OP_DIV);
        load_div   = in_valid && (op == OP_DIV);
      end
      S_DIV: begin
        div_step = 1'b1;
        div_last = (count == CW'(WIDTH - 1));
      end
      S_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Divide iteration counter
  always_ff @(posedge clk or negedge rst_n) begin : p_count
    if (!rst_n) begin
      count <= '0;
    end else if (load_div || div_last) begin
      count <= '0;
    end else if (div_step) begin
      count <= count + CW'(1);
    end
  end

  // Per-lane arithmetic and divider
  for (genvar g = 0; g < NCH; g++) begin : g_lane
    logic [WIDTH-1:0] a_l;
    logic [WIDTH-1:0] b_l;
    logic [DW-1:0]    ax;
    logic [DW-1:0]    bx;
    logic [DW-1:0]    arith_l;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_b;
    logic [WIDTH:0]   rsh;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign a_l = a[g*WIDTH +: WIDTH];
    assign b_l = b[g*WIDTH +: WIDTH];
    assign ax  = DW'(a_l);
    assign bx  = DW'(b_l);

    // Single-cycle ops at double width; SUB wraps modulo 2^DW
    always_comb begin : p_arith
      arith_l = ax + bx;
      case (op)
        OP_SUM:  arith_l = ax + bx;
        OP_SUB:  arith_l = ax - bx;
        OP_MUL:  arith_l = ax * bx;
        default: arith_l = ax + bx;
      endcase
    end

    // Restoring step: shift next dividend bit into the partial remainder,
    // subtract the divisor when it fits. A zero divisor always "fits", which
    // naturally yields an all-ones quotient and remainder equal to a.
    assign rsh      = {rem_q, quo_q[WIDTH-1]};
    assign diff     = rsh - {1'b0, div_b};
    assign ge       = (rsh >= {1'b0, div_b});
    assign rem_step = ge ? diff[WIDTH-1:0] : rsh[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], ge};

    // quo_q starts as the dividend and is shifted out as quotient bits enter
    always_ff @(posedge clk or negedge rst_n) begin : p_div
      if (!rst_n) begin
        rem_q <= '0;
        quo_q <= '0;
        div_b <= '0;
      end else if (load_div) begin
        rem_q <= '0;
        quo_q <= a_l;
        div_b <= b_l;
      end else if (div_step) begin
        rem_q <= rem_step;
        quo_q <= quo_step;
      end
    end

    assign arith_all[g*DW +: DW] = arith_l;
    assign dz_all[g]             = (div_b == '0);
`ifdef AU_REM_EN
    assign div_all[g*DW +: DW]   = {rem_step, quo_step};
`else
    assign div_all[g*DW +: DW]   = {{WIDTH{1'b0}}, quo_step};
`endif
  end

  // Result registers: written only on entry to DONE, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin : p_result
    if (!rst_n) begin
      out <= '0;
      dz  <= '0;
    end else if (load_arith) begin
      out <= arith_all;
      dz  <= '0;
    end else if (div_last) begin
      out <= div_all;
      dz  <= dz_all;
    end
  end

endmodule
